// File: rtl/wb_buffer_pkg.sv
// Shared types and width helpers for the write-back buffer slice.
// Holds the drain FSM state encoding, the default-width entry record and
// the pointer/count width helpers used by the top and the storage block.
package wb_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;

    // Drain FSM: IDLE presents nothing, DRAIN presents the head entry.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_t;

    // One buffered eviction at the default widths.
    typedef struct packed {
        logic                      valid;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Head/tail pointers wrap modulo depth, so log2(depth) bits suffice.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // The count must also represent "depth" itself (buffer full).
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);
    localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/wb_buffer_storage.sv
// Circular entry store for the write-back buffer.
// Owns the valid bits, head/tail pointers, occupancy count and the full
// flag. Accepts one append (push), one head removal (pop) and one in-place
// data overwrite (coalesce) per cycle; the top guarantees push and
// coalesce are never requested together.
module wb_buffer_storage
    import wb_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = ptr_width(DEPTH),
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_en,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_en,
    input  logic                  cw_en,
    input  logic [PTR_W-1:0]      cw_idx,
    input  logic [DATA_WIDTH-1:0] cw_data,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [ADDR_WIDTH-1:0] entry_addr [DEPTH],
    output logic [DATA_WIDTH-1:0] entry_data [DEPTH],
    output logic [PTR_W-1:0]      head,
    output logic [CNT_W-1:0]      count_next,
    output logic                  full
);

    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // Occupancy after this edge: appends add one, pops remove one.
    assign count_next = count + CNT_W'(push_en) - CNT_W'(pop_en);

    // Control state: pointers, count, full flag and per-entry valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            full        <= 1'b0;
            entry_valid <= '0;
        end else begin
            if (pop_en) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            // Ordered after the pop so that a push into the slot being
            // vacated this cycle (full buffer, push and pop) leaves it valid.
            if (push_en) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Entry payloads: no reset needed, valid bits gate every consumer.
    always_ff @(posedge clk) begin
        if (push_en) begin
            entry_addr[tail] <= push_addr;
            entry_data[tail] <= push_data;
        end
        if (cw_en) begin
            entry_data[cw_idx] <= cw_data;
        end
    end

endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer between the data cache eviction port and main memory.
// Buffers evicted words, coalesces repeat evictions of a waiting address,
// drains the oldest entry through a ready/valid handshake and forwards
// buffered data to the cache refill path.
// Optional feature macro: WB_BUFFER_FORWARD_EN enables the refill lookup
// comparators; without it fwd_hit/fwd_data are constant 0.
module write_back_buffer
    import wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evict_we,
    input  logic [ADDR_WIDTH-1:0] evict_addr,
    input  logic [DATA_WIDTH-1:0] evict_wd,
    output logic                  full,
    output logic                  overflow,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic                  mem_ready
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    wb_state_t             state;
    logic [DEPTH-1:0]      entry_valid;
    logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [CNT_W-1:0]      count_next;
    logic                  pop;
    logic                  accept;
    logic                  co_match;
    logic [PTR_W-1:0]      co_idx;
    logic                  push_new;
    logic                  co_write;

    // mem_we is the registered FSM state; a handshake pops the head.
    assign mem_we   = (state == DRAIN);
    assign pop      = mem_we && mem_ready;
    // A full buffer can still take a push if a slot frees up this cycle.
    assign accept   = !full || pop;
    assign push_new = evict_we && accept && !co_match;
    assign co_write = evict_we && accept && co_match;

    // Head is only driven while presented so idle outputs read as zero.
    assign mem_addr = mem_we ? entry_addr[head] : '0;
    assign mem_wd   = mem_we ? entry_data[head] : '0;

    // Push-side comparator: find the newest waiting entry with this address,
    // skipping the presented head whose data must not change mid-handshake.
    always_comb begin : coalesce_match
        logic [PTR_W-1:0] idx;
        co_match = 1'b0;
        co_idx   = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (entry_valid[idx] && (entry_addr[idx] == evict_addr) &&
                !(mem_we && (idx == head))) begin
                co_match = 1'b1;
                co_idx   = idx;
            end
        end
    end

    wb_buffer_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk         (clk),
        .rst         (rst),
        .push_en     (push_new),
        .push_addr   (evict_addr),
        .push_data   (evict_wd),
        .pop_en      (pop),
        .cw_en       (co_write),
        .cw_idx      (co_idx),
        .cw_data     (evict_wd),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
        .head        (head),
        .count_next  (count_next),
        .full        (full)
    );

    // Sticky error: an eviction arrived with no room and no slot freeing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (evict_we && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Drain FSM: present the head whenever the buffer will be non-empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (count_next != '0) state <= DRAIN;
                DRAIN:   if (count_next == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_BUFFER_FORWARD_EN
    // Refill forwarding over stored entries; newest match (nearest tail) wins.
    always_comb begin : fwd_mux
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (entry_valid[idx] && (entry_addr[idx] == lookup_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_addr;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_write_back_buffer.sv
// Self-checking bench for write_back_buffer with a drain scoreboard.
module tb_write_back_buffer;
    import wb_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        evict_we;
    logic [31:0] evict_addr;
    logic [31:0] evict_wd;
    logic        full;
    logic        overflow;
    logic [31:0] lookup_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_ready;

    wb_entry_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;

    write_back_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .evict_we    (evict_we),
        .evict_addr  (evict_addr),
        .evict_wd    (evict_wd),
        .full        (full),
        .overflow    (overflow),
        .lookup_addr (lookup_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wd      (mem_wd),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake seen mid-cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL drain_unexpected: got addr %h data %h, required no write", mem_addr, mem_wd);
            end else begin
                wb_entry_t e;
                e = sb_q.pop_front();
                if (mem_addr !== e.addr || mem_wd !== e.data) begin
                    n_fail++;
                    $display("FAIL drain_order: got addr %h data %h, required addr %h data %h",
                             mem_addr, mem_wd, e.addr, e.data);
                end
                n_popped++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic wb_entry_t mk(input logic [31:0] a, input logic [31:0] d);
        wb_entry_t e;
        e.valid = 1'b1;
        e.addr  = a;
        e.data  = d;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain_wait(output bit timed_out);
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!mem_we) break;
        end
        timed_out = mem_we;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
        n_checks++; if (mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wd: got %h, required 0", mem_wd); end
        n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit: got %b, required 0", fwd_hit); end
        n_checks++; if (fwd_data !== 32'h0) begin n_fail++; $display("FAIL reset_fwd_data: got %h, required 0", fwd_data); end
        rst = 1'b0;
        tick();
        // mem_ready with nothing presented must not start a drain.
        mem_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_ready_ignored: got mem_we %b, required 0", mem_we); end
        mem_ready = 1'b0;
    endtask

    task automatic test_single_hold();
        sb_q.push_back(mk(32'h100, 32'hDEADBEEF));
        evict_we = 1'b1; evict_addr = 32'h100; evict_wd = 32'hDEADBEEF;
        tick();
        evict_we = 1'b0;
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL latency_mem_we: got %b, required 1", mem_we); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL latency_mem_addr: got %h, required 100", mem_addr); end
        n_checks++; if (mem_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL latency_mem_wd: got %h, required deadbeef", mem_wd); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wd !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got we %b addr %h data %h, required we 1 addr 100 data deadbeef",
                         i, mem_we, mem_addr, mem_wd);
            end
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_pop_we: got %b, required 0", mem_we); end
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL single_drained: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_full_overflow();
        bit to;
        int base;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, d;
            a = 32'h1000 + 32'(i * 4);
            d = $urandom;
            sb_q.push_back(mk(a, d));
            evict_we = 1'b1; evict_addr = a; evict_wd = d;
            tick();
        end
        evict_we = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after4: got %b, required 1", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL no_overflow_yet: got %b, required 0", overflow); end
        evict_we = 1'b1; evict_addr = 32'h2000; evict_wd = 32'h55;
        tick();
        evict_we = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b, required 1", overflow); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop: got %b, required 1", full); end
        base = n_popped;
        drain_wait(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL overflow_drain_timeout: got mem_we 1, required 0"); end
        n_checks++; if (n_popped - base != 4) begin n_fail++; $display("FAIL overflow_drain_count: got %0d, required 4", n_popped - base); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b, required 1", overflow); end
        do_reset();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_cleared: got %b, required 0", overflow); end
    endtask

    task automatic test_coalesce();
        bit to;
        int base;
        sb_q.push_back(mk(32'h200, 32'h1));
        evict_we = 1'b1; evict_addr = 32'h200; evict_wd = 32'h1;
        tick();
        sb_q.push_back(mk(32'h300, 32'h2));
        evict_addr = 32'h300; evict_wd = 32'h2;
        tick();
        sb_q[1].data = 32'h3;
        evict_addr = 32'h300; evict_wd = 32'h3;
        tick();
        n_checks++; if (mem_addr !== 32'h200 || mem_wd !== 32'h1) begin n_fail++; $display("FAIL coalesce_head_stable: got %h/%h, required 200/1", mem_addr, mem_wd); end
        sb_q.push_back(mk(32'h200, 32'h9));
        evict_addr = 32'h200; evict_wd = 32'h9;
        tick();
        evict_we = 1'b0;
        n_checks++; if (mem_wd !== 32'h1) begin n_fail++; $display("FAIL head_not_coalesced: got %h, required 1", mem_wd); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL coalesce_count3: got full %b, required 0", full); end
        base = n_popped;
        drain_wait(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL coalesce_drain_timeout: got mem_we 1, required 0"); end
        n_checks++; if (n_popped - base != 3) begin n_fail++; $display("FAIL coalesce_drain_count: got %0d, required 3", n_popped - base); end
    endtask

    task automatic test_forward();
        bit to;
        logic        exp_hit;
        logic [31:0] exp_aa, exp_bb;
`ifdef WB_BUFFER_FORWARD_EN
        exp_hit = 1'b1; exp_aa = 32'hAA; exp_bb = 32'hBB;
`else
        exp_hit = 1'b0; exp_aa = 32'h0;  exp_bb = 32'h0;
`endif
        sb_q.push_back(mk(32'h400, 32'hAA));
        evict_we = 1'b1; evict_addr = 32'h400; evict_wd = 32'hAA;
        lookup_addr = 32'h400;
        #1;
        n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle_push: got %b, required 0", fwd_hit); end
        tick();
        evict_we = 1'b0;
        #1;
        n_checks++; if (fwd_hit !== exp_hit) begin n_fail++; $display("FAIL fwd_hit_400: got %b, required %b", fwd_hit, exp_hit); end
        n_checks++; if (fwd_data !== exp_aa) begin n_fail++; $display("FAIL fwd_data_400: got %h, required %h", fwd_data, exp_aa); end
        lookup_addr = 32'h404;
        #1;
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_fail++; $display("FAIL fwd_miss_404: got %b/%h, required 0/0", fwd_hit, fwd_data); end
        sb_q.push_back(mk(32'h400, 32'hBB));
        evict_we = 1'b1; evict_addr = 32'h400; evict_wd = 32'hBB;
        tick();
        evict_we = 1'b0;
        lookup_addr = 32'h400;
        #1;
        n_checks++; if (fwd_data !== exp_bb) begin n_fail++; $display("FAIL fwd_newest_wins: got %h, required %h", fwd_data, exp_bb); end
        drain_wait(to);
        n_checks++; if (to || sb_q.size() != 0) begin n_fail++; $display("FAIL fwd_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_full_push_pop_and_reset();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, d;
            a = 32'h3000 + 32'(i * 4);
            d = 32'hC0 + 32'(i);
            sb_q.push_back(mk(a, d));
            evict_we = 1'b1; evict_addr = a; evict_wd = d;
            tick();
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b, required 1", full); end
        sb_q.push_back(mk(32'h5000, 32'h77));
        evict_addr = 32'h5000; evict_wd = 32'h77; mem_ready = 1'b1;
        tick();
        evict_we = 1'b0; mem_ready = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full_stays: got %b, required 1", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_no_overflow: got %b, required 0", overflow); end
        n_checks++; if (mem_addr !== sb_q[0].addr) begin n_fail++; $display("FAIL fpp_new_head: got %h, required %h", mem_addr, sb_q[0].addr); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_drain_we: got %b, required 1", mem_we); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL async_rst_we: got %b, required 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin n_fail++; $display("FAIL async_rst_mem: got %h/%h, required 0/0", mem_addr, mem_wd); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL async_rst_full: got %b, required 0", full); end
        sb_q.delete();
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_empty%0d: got mem_we %b, required 0", i, mem_we); end
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; evict_we = 1'b0; evict_addr = '0; evict_wd = '0;
        lookup_addr = '0; mem_ready = 1'b0;
        test_reset();
        test_single_hold();
        test_full_overflow();
        test_coalesce();
        test_forward();
        test_full_push_pop_and_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
